axis_packet_fifo: RTL and testbench

Parametrised AXI-Stream packet buffer between a stream producer and consumer. It is the generalised successor of the fixed 8-word, 16-bit loopback buffer. Data width, depth and forwarding mode are configurable. It provides true tready backpressure, packet counting, and a store-and-forward mode that releases only complete (tlast-terminated) packets.

---
 rtl/axis_packet_fifo.sv | 109 ++++++++++
 tb/tb_axis_packet_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
// AXI-Stream packet FIFO: first-word-fall-through buffer with packet
// counting, optional store-and-forward release, and an oversize escape
// that drains a packet too long to fit in cut-through fashion.
module axis_packet_fifo #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 8,
  parameter int STORE_FWD = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [AW:0]       occupancy,
  output logic [AW:0]       pkt_count,
  output logic              full,
  output logic              empty,
  output logic              oversize_err
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // {tlast, tdata} per entry; contents are never reset
  logic [DATA_W:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW:0]   pkt_q, pkt_d;
  logic          rel_q, rel_d;
  logic          err_q, err_d;

  logic          push, pop, head_last, trig;

  // Status and handshake, all from registered state (no m_tready -> s_tready path)
  always_comb begin
    full      = (occ_q == FULL_LVL);
    empty     = (occ_q == '0);
    s_tready  = !full;
    head_last = mem_q[rd_ptr_q][DATA_W];
    if (STORE_FWD != 0) m_tvalid = !empty && ((pkt_q != '0) || rel_q);
    else                m_tvalid = !empty;
    m_tdata   = m_tvalid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
    m_tlast   = m_tvalid && head_last;
    push      = s_tvalid && s_tready;
    pop       = m_tvalid && m_tready;
    // Full with no complete packet stored can never release on its own
    trig      = (STORE_FWD != 0) && full && (pkt_q == '0);
    occupancy    = occ_q;
    pkt_count    = pkt_q;
    oversize_err = err_q;
  end

  // Next-state for pointers, counters and release/error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pkt_d    = pkt_q;
    rel_d    = rel_q;
    err_d    = err_q | trig;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
    case ({push && s_tlast, pop && head_last})
      2'b10:   pkt_d = pkt_q + (AW+1)'(1);
      2'b01:   pkt_d = pkt_q - (AW+1)'(1);
      default: pkt_d = pkt_q;
    endcase
    // Release ends once the oversize packet's tail leaves
    if (pop && head_last) rel_d = 1'b0;
    else if (trig)        rel_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pkt_q    <= '0;
      rel_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pkt_q    <= pkt_d;
      rel_q    <= rel_d;
      err_q    <= err_d;
    end
  end

  // Storage write on accepted beat
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_tlast, s_tdata};
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Randomized bench for axis_packet_fifo: one cut-through and one
// store-and-forward instance, checked every cycle against a queue model.
module tb_axis_packet_fifo;
  localparam int DW = 16, DEPTH = 8, AW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          sel = 1'b0;  // 0: cut-through instance, 1: store-and-forward
  logic          tv = 1'b0, tl = 1'b0, mr = 1'b0;
  logic [DW-1:0] td = '0;

  logic          c_str, c_mv, c_ml, c_full, c_empty, c_err;
  logic [DW-1:0] c_md;
  logic [AW:0]   c_occ, c_pkt;
  logic          f_str, f_mv, f_ml, f_full, f_empty, f_err;
  logic [DW-1:0] f_md;
  logic [AW:0]   f_occ, f_pkt;

  axis_packet_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .STORE_FWD(0)) u_ct (
    .clk(clk), .reset(reset),
    .s_tvalid(tv & ~sel), .s_tready(c_str), .s_tdata(td), .s_tlast(tl),
    .m_tvalid(c_mv), .m_tready(mr & ~sel), .m_tdata(c_md), .m_tlast(c_ml),
    .occupancy(c_occ), .pkt_count(c_pkt), .full(c_full), .empty(c_empty),
    .oversize_err(c_err));

  axis_packet_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .STORE_FWD(1)) u_sf (
    .clk(clk), .reset(reset),
    .s_tvalid(tv & sel), .s_tready(f_str), .s_tdata(td), .s_tlast(tl),
    .m_tvalid(f_mv), .m_tready(mr & sel), .m_tdata(f_md), .m_tlast(f_ml),
    .occupancy(f_occ), .pkt_count(f_pkt), .full(f_full), .empty(f_empty),
    .oversize_err(f_err));

  logic          o_str, o_mv, o_ml, o_full, o_empty, o_err;
  logic [DW-1:0] o_md;
  logic [AW:0]   o_occ, o_pkt;
  always_comb begin
    o_str   = sel ? f_str   : c_str;
    o_mv    = sel ? f_mv    : c_mv;
    o_ml    = sel ? f_ml    : c_ml;
    o_full  = sel ? f_full  : c_full;
    o_empty = sel ? f_empty : c_empty;
    o_err   = sel ? f_err   : c_err;
    o_md    = sel ? f_md    : c_md;
    o_occ   = sel ? f_occ   : c_occ;
    o_pkt   = sel ? f_pkt   : c_pkt;
  end

  // Reference model: queue of stored beats {last,data} plus release/error flags
  logic [DW:0] q[$];
  bit          rel, err;
  int          n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  function automatic int mpk();
    int n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return n;
  endfunction

  // One clock: check outputs against model, drive inputs, advance model
  task automatic step(input logic v, input logic [DW-1:0] d, input logic l,
                      input logic r, output bit acc);
    int          pk;
    bit          efull, emv, pop;
    logic [DW:0] h;
    pk    = mpk();
    efull = (q.size() == DEPTH);
    emv   = (q.size() != 0) && (!sel || pk != 0 || rel);
    h     = (q.size() != 0) ? q[0] : '0;
    chk("m_tvalid",  32'(o_mv),    32'(emv));
    chk("m_tdata",   32'(o_md),    emv ? 32'(h[DW-1:0]) : 32'd0);
    chk("m_tlast",   32'(o_ml),    emv ? 32'(h[DW]) : 32'd0);
    chk("occupancy", 32'(o_occ),   32'(q.size()));
    chk("pkt_count", 32'(o_pkt),   32'(pk));
    chk("full",      32'(o_full),  32'(efull));
    chk("empty",     32'(o_empty), 32'(q.size() == 0));
    chk("s_tready",  32'(o_str),   32'(!efull));
    chk("oversize",  32'(o_err),   32'(err));
    tv = v; td = d; tl = l; mr = r;
    acc = v && !efull;
    pop = emv && r;
    if (pop && h[DW]) rel = 1'b0;
    else if (sel && efull && pk == 0) begin rel = 1'b1; err = 1'b1; end
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({l, d});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold one beat on the input until accepted (bounded)
  task automatic send(input logic [DW-1:0] d, input logic l, input logic r);
    bit acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) step(1'b1, d, l, r, acc);
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_rst(input logic s);
    tv = 1'b0; mr = 1'b0; tl = 1'b0; td = '0;
    sel = s; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q.delete(); rel = 1'b0; err = 1'b0;
  endtask

  // Random traffic: producer holds each beat until accepted, packet lengths 1..maxlen
  task automatic rnd(input int ncyc, input int maxlen, input int pv, input int pr);
    bit            have = 1'b0, acc;
    int            rem = 0;
    logic [DW-1:0] d = '0;
    logic          l = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!have) begin
        if (rem == 0) rem = $urandom_range(1, maxlen);
        d = DW'($urandom); l = (rem == 1); have = 1'b1;
      end
      step(($urandom % 100) < pv, d, l, ($urandom % 100) < pr, acc);
      if (acc) begin have = 1'b0; rem--; end
    end
    while (rem > 0) begin
      if (!have) begin d = DW'($urandom); l = (rem == 1); end
      send(d, l, 1'b1);
      have = 1'b0; rem--;
    end
    drain(4 * DEPTH);
  endtask

  logic [DW-1:0] pkt8 [8] = '{16'd10, 16'd100, 16'd125, 16'd130,
                              16'd150, 16'd165, 16'd180, 16'd240};

  initial begin
    bit acc;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Cut-through 8-beat packet, sink always ready
    do_rst(1'b0);
    for (int i = 0; i < 8; i++) send(pkt8[i], i == 7, 1'b1);
    drain(3);

    // Store-and-forward, same packet
    do_rst(1'b1);
    for (int i = 0; i < 8; i++) send(pkt8[i], i == 7, 1'b1);
    drain(10);

    // Backpressure: fill, refused 9th beat, then release sink
    do_rst(1'b0);
    for (int i = 0; i < 8; i++) send(DW'(i + 16'h50), i == 7, 1'b0);
    step(1'b1, 16'h99, 1'b1, 1'b0, acc);
    step(1'b1, 16'h99, 1'b1, 1'b0, acc);
    send(16'h99, 1'b1, 1'b1);
    drain(12);

    // Simultaneous push/pop around occupancy 4, then wrap-around traffic
    do_rst(1'b0);
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, DW'($urandom), ($urandom % 4) == 0, ($urandom % 4) != 0, acc);
    drain(12);
    rnd(300, 5, 70, 60);

    // Oversize packet then a normal 3-beat packet
    do_rst(1'b1);
    for (int i = 0; i < 12; i++) send(DW'(16'h100 + i), i == 11, 1'b1);
    for (int i = 0; i < 3; i++) send(DW'(16'h200 + i), i == 2, 1'b1);
    drain(12);

    // Random store-and-forward traffic, some packets oversize
    rnd(400, 10, 70, 60);

    // Reset mid-packet at occupancy 5 (error flag is set here), then 2-beat packet
    for (int i = 0; i < 5; i++) send(DW'(16'h300 + i), 1'b0, 1'b1);
    chk("pre_rst_occ", 32'(o_occ), 32'd5);
    do_rst(1'b1);
    send(16'h401, 1'b0, 1'b1);
    send(16'h402, 1'b1, 1'b1);
    drain(6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
